decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width of register data and Reg1/Reg2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 instr  input  32  MIPS instruction word from fetch.
REQ-005 instr_valid  input  1  instr holds a real instruction this cycle.
REQ-006 instr_ready  output  1  decode accepts instr this cycle (combinational).
REQ-007 stall  input  1  downstream exe stage cannot take a new instruction; hold outputs.
REQ-008 wb_en  input  1  writeback write enable.
REQ-009 wb_addr  input  5  writeback destination register.
REQ-010 wb_data  input  WIDTH  writeback data.
REQ-011 ALUSrc  output  1  1 = exe uses Immediate as operand B, 0 = Reg2.
REQ-012 ALUOp  output  4  ALU operation for exe.
REQ-013 Immediate  output  16  instr[15:0], raw; exe performs the extension.
REQ-014 Reg1  output  WIDTH  value of register rs.
REQ-015 Reg2  output  WIDTH  value of register rt.
REQ-016 DestReg  output  5  destination register: rd for R-type, rt for I-type.
REQ-017 RegWrite, MemRead, MemWrite, Branch  output  1 each  downstream control.
REQ-018 out_valid  output  1  ID/EX register holds a real instruction.
REQ-019 illegal  output  1  sticky flag, unsupported opcode/funct seen.

Function
REQ-020 Register file: 32 x WIDTH; register 0 SHALL always read 0 and ignore writes.
REQ-021 wb_en write SHALL occur at the rising edge; same-cycle read of wb_addr (nonzero) SHALL return wb_data (write-through bypass).
REQ-022 ID/EX outputs SHALL be registered; latency instr accept -> outputs valid = 1 cycle.
REQ-023 ALUOp encoding: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-024 R-type (op 0x00) funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT; ALUSrc=0, RegWrite=1.
REQ-025 I-type: addi 0x08 ADD, slti 0x0A SLT, andi 0x0C AND, ori 0x0D OR; ALUSrc=1, RegWrite=1.
REQ-026 lw 0x23: ADD, ALUSrc=1, MemRead=1, RegWrite=1; sw 0x2B: ADD, ALUSrc=1, MemWrite=1; beq 0x04: SUB, ALUSrc=0, Branch=1.
REQ-027 Unsupported op/funct SHALL be issued as a bubble (out_valid=0, all controls 0) and set illegal until rst.
REQ-028 Writes to DestReg=0 SHALL issue with RegWrite=0.
REQ-029 instr_ready = !stall && !hazard; instruction accepted when instr_valid && instr_ready.
REQ-030 stall=1: all ID/EX outputs SHALL hold their values unchanged; stall has priority over hazard and new accepts.
REQ-031 Not stalled and no accept: next cycle out_valid=0, RegWrite/MemRead/MemWrite/Branch=0 (bubble).
REQ-032 Load-use hazard: hazard=1 when out_valid && MemRead && DestReg!=0 && instr_valid && (DestReg==rs || (DestReg==rt && instr is R-type/sw/beq)).
REQ-033 On hazard (not stalled): insert exactly one bubble; instr held upstream and accepted the following cycle.
REQ-034 Reg1/Reg2 SHALL be read in the accepting cycle, including the wb bypass.

Reset
REQ-035 On rst=1 at a clock edge: out_valid, ALUSrc, ALUOp, Immediate, Reg1, Reg2, DestReg, all controls and illegal SHALL clear to 0.
REQ-036 All 32 registers SHALL clear to 0 on rst; rst mid-stall or mid-hazard SHALL discard the in-flight instruction.
REQ-037 rst SHALL override wb_en, stall and instr_valid in the same cycle.

Verification
REQ-038 wb r1=5, r2=7; instr add r3,r1,r2 (0x00221820) -> next cycle ALUOp=0010, ALUSrc=0, Reg1=5, Reg2=7, DestReg=3, RegWrite=1, out_valid=1.
REQ-039 addi r4,r0,0xFFFF (0x2004FFFF) -> ALUSrc=1, Immediate=0xFFFF, Reg1=0, ALUOp=0010, DestReg=4.
REQ-040 lw r5,0(r1) then add r6,r5,r5 back-to-back -> instr_ready=0 for one cycle, one bubble (out_valid=0), then the add issues.
REQ-041 stall=1 for 3 cycles with a valid add issued -> outputs constant for 3 cycles, instr_ready=0; release -> next instr issues.
REQ-042 wb_en=1, wb_addr=1, wb_data=0xDEADBEEF same cycle as or r2,r1,r0 accepted -> Reg1=0xDEADBEEF; write to r0 -> r0 reads 0.
REQ-043 opcode 0x3F -> bubble, illegal=1 and stays 1; rst -> illegal=0, all outputs 0.

Source files
------------

// File: rtl/decode.sv
`default_nettype none
// ============================================================================
// Module   : decode
// Purpose  : MIPS-subset instruction decode stage. It holds a 32-entry
//            register file with write-through bypass, decodes opcode/funct
//            into ALU and memory controls, detects load-use hazards, and
//            drives a registered ID/EX pipeline register.
// Ports    : clk, rst (sync, active-high)
//            instr/instr_valid/instr_ready : handshake from fetch
//            stall                         : exe back-pressure, holds ID/EX
//            wb_en/wb_addr/wb_data         : register-file write port
//            ALUSrc, ALUOp, Immediate, Reg1, Reg2, DestReg,
//            RegWrite, MemRead, MemWrite, Branch, out_valid : ID/EX register
//            illegal                       : sticky unsupported-instruction flag
// Revision : 1.0 - initial release
// ============================================================================
module decode #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             stall,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             ALUSrc,
  output logic [3:0]       ALUOp,
  output logic [15:0]      Immediate,
  output logic [WIDTH-1:0] Reg1,
  output logic [WIDTH-1:0] Reg2,
  output logic [4:0]       DestReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             out_valid,
  output logic             illegal
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Instruction fields
  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];

  // Register file; entry 0 is never written and is masked on read.
  logic [WIDTH-1:0] rf [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_en && (wb_addr != 5'd0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Read ports with write-through bypass of a same-cycle writeback.
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rs != 5'd0) begin
      rd_data1 = (wb_en && (wb_addr == rs)) ? wb_data : rf[rs];
    end
    if (rt != 5'd0) begin
      rd_data2 = (wb_en && (wb_addr == rt)) ? wb_data : rf[rt];
    end
  end

  // Instruction decode
  logic       dec_ok;
  logic [3:0] dec_alu_op;
  logic       dec_alu_src;
  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_branch;
  logic [4:0] dec_dest;
  logic       uses_rt;     // rt is a source operand (R-type, sw, beq)

  always_comb begin
    dec_ok        = 1'b0;
    dec_alu_op    = ALU_AND;
    dec_alu_src   = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_dest      = rt;
    uses_rt       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_dest      = rd;
        uses_rt       = 1'b1;
        dec_reg_write = 1'b1;
        dec_ok        = 1'b1;
        case (funct)
          FN_ADD:  dec_alu_op = ALU_ADD;
          FN_SUB:  dec_alu_op = ALU_SUB;
          FN_AND:  dec_alu_op = ALU_AND;
          FN_OR:   dec_alu_op = ALU_OR;
          FN_NOR:  dec_alu_op = ALU_NOR;
          FN_SLT:  dec_alu_op = ALU_SLT;
          default: dec_ok     = 1'b0;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        dec_ok        = 1'b1;
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
        case (opcode)
          OP_SLTI: dec_alu_op = ALU_SLT;
          OP_ANDI: dec_alu_op = ALU_AND;
          OP_ORI:  dec_alu_op = ALU_OR;
          default: dec_alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        dec_ok        = 1'b1;
        dec_alu_op    = ALU_ADD;
        dec_alu_src   = 1'b1;
        dec_mem_read  = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_SW: begin
        dec_ok        = 1'b1;
        dec_alu_op    = ALU_ADD;
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_BEQ: begin
        dec_ok     = 1'b1;
        dec_alu_op = ALU_SUB;
        dec_branch = 1'b1;
        uses_rt    = 1'b1;
      end
      default: ;
    endcase
  end

  // Load-use hazard: the load in ID/EX produces a register this instruction
  // reads. rt only counts as a source for formats that actually read it.
  logic hazard;
  logic accept;

  assign hazard = out_valid && MemRead && (DestReg != 5'd0) && instr_valid &&
                  ((DestReg == rs) || ((DestReg == rt) && uses_rt));

  assign instr_ready = !stall && !hazard;
  assign accept      = instr_valid && instr_ready;

  // ID/EX pipeline register. Stall freezes everything; any cycle without a
  // legal accept becomes a bubble (data fields are don't-care and kept).
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ALUSrc    <= 1'b0;
      ALUOp     <= '0;
      Immediate <= '0;
      Reg1      <= '0;
      Reg2      <= '0;
      DestReg   <= '0;
      RegWrite  <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      Branch    <= 1'b0;
      illegal   <= 1'b0;
    end else if (!stall) begin
      if (accept && dec_ok) begin
        out_valid <= 1'b1;
        ALUSrc    <= dec_alu_src;
        ALUOp     <= dec_alu_op;
        Immediate <= instr[15:0];
        Reg1      <= rd_data1;
        Reg2      <= rd_data2;
        DestReg   <= dec_dest;
        // Writes targeting r0 are suppressed here so later stages need not care.
        RegWrite  <= dec_reg_write && (dec_dest != 5'd0);
        MemRead   <= dec_mem_read;
        MemWrite  <= dec_mem_write;
        Branch    <= dec_branch;
      end else begin
        out_valid <= 1'b0;
        ALUSrc    <= 1'b0;
        ALUOp     <= '0;
        RegWrite  <= 1'b0;
        MemRead   <= 1'b0;
        MemWrite  <= 1'b0;
        Branch    <= 1'b0;
        if (accept) begin
          illegal <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode
// Purpose  : Directed self-checking bench for decode. Inputs are driven 1 ns
//            after each rising edge and outputs are sampled at that point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ALUSrc;
  logic [3:0]  ALUOp;
  logic [15:0] Immediate;
  logic [31:0] Reg1;
  logic [31:0] Reg2;
  logic [4:0]  DestReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Branch;
  logic        out_valid;
  logic        illegal;

  int passed;
  int total;

  decode #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .Immediate(Immediate),
    .Reg1(Reg1), .Reg2(Reg2), .DestReg(DestReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .out_valid(out_valid), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] w);
    instr = w; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passed++;
    total++; if (illegal !== 1'b0) $display("FAIL rst_illegal: got %b want 0", illegal); else passed++;
    total++; if (ALUOp !== 4'b0000) $display("FAIL rst_aluop: got %b want 0000", ALUOp); else passed++;
    total++; if (Reg1 !== 32'd0 || Reg2 !== 32'd0) $display("FAIL rst_regs: got %h %h want 0 0", Reg1, Reg2); else passed++;
    total++; if (DestReg !== 5'd0 || Immediate !== 16'd0) $display("FAIL rst_dest_imm: got %0d %h want 0 0", DestReg, Immediate); else passed++;
    total++; if ({RegWrite, MemRead, MemWrite, Branch, ALUSrc} !== 5'b0) $display("FAIL rst_ctrl: got %b want 00000", {RegWrite, MemRead, MemWrite, Branch, ALUSrc}); else passed++;
    rst = 1'b0;
    #1;
    total++; if (instr_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", instr_ready); else passed++;
  endtask

  task automatic test_rtype();
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    issue(32'h00221820);                 // add r3,r1,r2
    total++; if (ALUOp !== 4'b0010) $display("FAIL add_aluop: got %b want 0010", ALUOp); else passed++;
    total++; if (ALUSrc !== 1'b0) $display("FAIL add_alusrc: got %b want 0", ALUSrc); else passed++;
    total++; if (Reg1 !== 32'd5 || Reg2 !== 32'd7) $display("FAIL add_regs: got %0d %0d want 5 7", Reg1, Reg2); else passed++;
    total++; if (DestReg !== 5'd3) $display("FAIL add_dest: got %0d want 3", DestReg); else passed++;
    total++; if (RegWrite !== 1'b1 || out_valid !== 1'b1) $display("FAIL add_rw_valid: got %b %b want 1 1", RegWrite, out_valid); else passed++;
    tick();                              // no accept -> bubble
    total++; if (out_valid !== 1'b0 || RegWrite !== 1'b0) $display("FAIL bubble: got valid=%b rw=%b want 0 0", out_valid, RegWrite); else passed++;
    issue(32'h00221822);                 // sub
    total++; if (ALUOp !== 4'b0110) $display("FAIL sub_aluop: got %b want 0110", ALUOp); else passed++;
    issue(32'h0022182A);                 // slt
    total++; if (ALUOp !== 4'b0111) $display("FAIL slt_aluop: got %b want 0111", ALUOp); else passed++;
    issue(32'h00221827);                 // nor
    total++; if (ALUOp !== 4'b1100) $display("FAIL nor_aluop: got %b want 1100", ALUOp); else passed++;
    issue(32'h00221824);                 // and
    total++; if (ALUOp !== 4'b0000 || out_valid !== 1'b1) $display("FAIL and_aluop: got %b v=%b want 0000 1", ALUOp, out_valid); else passed++;
  endtask

  task automatic test_itype();
    issue(32'h2004FFFF);                 // addi r4,r0,0xFFFF
    total++; if (ALUSrc !== 1'b1) $display("FAIL addi_alusrc: got %b want 1", ALUSrc); else passed++;
    total++; if (Immediate !== 16'hFFFF) $display("FAIL addi_imm: got %h want ffff", Immediate); else passed++;
    total++; if (Reg1 !== 32'd0 || ALUOp !== 4'b0010) $display("FAIL addi_reg1_op: got %h %b want 0 0010", Reg1, ALUOp); else passed++;
    total++; if (DestReg !== 5'd4 || RegWrite !== 1'b1) $display("FAIL addi_dest: got %0d rw=%b want 4 1", DestReg, RegWrite); else passed++;
    issue(32'h342200F0);                 // ori r2,r1,0xF0
    total++; if (ALUOp !== 4'b0001 || Reg1 !== 32'd5 || DestReg !== 5'd2) $display("FAIL ori: got %b %0d %0d want 0001 5 2", ALUOp, Reg1, DestReg); else passed++;
    issue(32'h20200001);                 // addi r0,r1,1
    total++; if (RegWrite !== 1'b0 || out_valid !== 1'b1) $display("FAIL r0_dest: got rw=%b v=%b want 0 1", RegWrite, out_valid); else passed++;
    issue(32'hAC220004);                 // sw r2,4(r1)
    total++; if ({MemWrite, RegWrite, MemRead, ALUSrc} !== 4'b1001 || ALUOp !== 4'b0010) $display("FAIL sw: got %b %b want 1001 0010", {MemWrite, RegWrite, MemRead, ALUSrc}, ALUOp); else passed++;
    issue(32'h10220003);                 // beq r1,r2
    total++; if ({Branch, RegWrite, ALUSrc} !== 3'b100 || ALUOp !== 4'b0110) $display("FAIL beq: got %b %b want 100 0110", {Branch, RegWrite, ALUSrc}, ALUOp); else passed++;
  endtask

  task automatic test_load_use();
    issue(32'h8C250000);                 // lw r5,0(r1)
    total++; if (MemRead !== 1'b1 || RegWrite !== 1'b1 || DestReg !== 5'd5) $display("FAIL lw: got mr=%b rw=%b d=%0d want 1 1 5", MemRead, RegWrite, DestReg); else passed++;
    instr = 32'h00A53020; instr_valid = 1'b1;   // add r6,r5,r5
    #1;
    total++; if (instr_ready !== 1'b0) $display("FAIL lu_ready0: got %b want 0", instr_ready); else passed++;
    #(-1ns + 1ns);
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL lu_bubble: got %b want 0", out_valid); else passed++;
    total++; if (instr_ready !== 1'b1) $display("FAIL lu_ready1: got %b want 1", instr_ready); else passed++;
    tick();
    instr_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || DestReg !== 5'd6 || ALUOp !== 4'b0010) $display("FAIL lu_issue: got v=%b d=%0d op=%b want 1 6 0010", out_valid, DestReg, ALUOp); else passed++;
    // Load followed by an I-type whose rt is the load target: rt is a destination, no hazard.
    issue(32'h8C250000);
    instr = 32'h20250001; instr_valid = 1'b1;   // addi r5,r1,1
    #1;
    total++; if (instr_ready !== 1'b1) $display("FAIL lu_itype_ready: got %b want 1", instr_ready); else passed++;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_stall();
    issue(32'h00221820);                 // add r3,r1,r2
    stall = 1'b1;
    instr = 32'h00221822; instr_valid = 1'b1;
    #1;
    total++; if (instr_ready !== 1'b0) $display("FAIL stall_ready: got %b want 0", instr_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b1 || ALUOp !== 4'b0010 || DestReg !== 5'd3 || Reg1 !== 32'd5 || Reg2 !== 32'd7 || RegWrite !== 1'b1)
        $display("FAIL stall_hold%0d: got v=%b op=%b d=%0d r1=%0d r2=%0d want 1 0010 3 5 7", i, out_valid, ALUOp, DestReg, Reg1, Reg2);
      else passed++;
    end
    stall = 1'b0;
    #1;
    total++; if (instr_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", instr_ready); else passed++;
    tick();
    instr_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || ALUOp !== 4'b0110) $display("FAIL stall_release: got v=%b op=%b want 1 0110", out_valid, ALUOp); else passed++;
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hDEADBEEF;
    issue(32'h00201025);                 // or r2,r1,r0
    wb_en = 1'b0;
    total++; if (Reg1 !== 32'hDEADBEEF || Reg2 !== 32'd0) $display("FAIL bypass: got %h %h want deadbeef 0", Reg1, Reg2); else passed++;
    issue(32'h00221820);                 // add r3,r1,r2 reads stored value
    total++; if (Reg1 !== 32'hDEADBEEF || Reg2 !== 32'd7) $display("FAIL stored: got %h %0d want deadbeef 7", Reg1, Reg2); else passed++;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h12345678;
    issue(32'h00001820);                 // add r3,r0,r0 with r0 write same cycle
    wb_en = 1'b0;
    total++; if (Reg1 !== 32'd0 || Reg2 !== 32'd0) $display("FAIL r0_bypass: got %h %h want 0 0", Reg1, Reg2); else passed++;
    issue(32'h00001820);
    total++; if (Reg1 !== 32'd0) $display("FAIL r0_read: got %h want 0", Reg1); else passed++;
  endtask

  task automatic test_illegal_and_reset();
    issue(32'h00221821);                 // unsupported funct
    total++; if (out_valid !== 1'b0 || illegal !== 1'b1 || RegWrite !== 1'b0) $display("FAIL bad_funct: got v=%b ill=%b rw=%b want 0 1 0", out_valid, illegal, RegWrite); else passed++;
    issue(32'h00221820);
    total++; if (out_valid !== 1'b1 || illegal !== 1'b1) $display("FAIL ill_sticky: got v=%b ill=%b want 1 1", out_valid, illegal); else passed++;
    issue(32'hFC000000);                 // opcode 0x3F
    total++; if (out_valid !== 1'b0 || illegal !== 1'b1 || ALUOp !== 4'b0000 || {RegWrite, MemRead, MemWrite, Branch, ALUSrc} !== 5'b0)
      $display("FAIL bad_op: got v=%b ill=%b op=%b want 0 1 0000", out_valid, illegal, ALUOp);
    else passed++;
    issue(32'h00221820);
    // Reset while stalled with a writeback and a new instruction pending.
    stall = 1'b1; rst = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
    instr = 32'h00221820; instr_valid = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || illegal !== 1'b0 || ALUOp !== 4'b0000 || DestReg !== 5'd0 || Reg1 !== 32'd0 || Reg2 !== 32'd0 || Immediate !== 16'd0 || RegWrite !== 1'b0)
      $display("FAIL rst_mid: got v=%b ill=%b op=%b d=%0d r1=%h want all 0", out_valid, illegal, ALUOp, DestReg, Reg1);
    else passed++;
    rst = 1'b0; stall = 1'b0; wb_en = 1'b0;
    tick();
    instr_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || Reg1 !== 32'd0 || Reg2 !== 32'd0) $display("FAIL rf_cleared: got v=%b %h %h want 1 0 0", out_valid, Reg1, Reg2); else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    rst = 1'b1; instr = 32'd0; instr_valid = 1'b0; stall = 1'b0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    test_reset();
    test_rtype();
    test_itype();
    test_load_use();
    test_stall();
    test_bypass();
    test_illegal_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
